// File: rtl/integral_image_gen.sv
// ---------------------------------------------------------------------------
// integral_image_gen
//   Turns a raster-order grayscale pixel stream (one tile) into its
//   summed-area image II(x,y) = sum p(i,j), i<=x, j<=y. Each word is emitted
//   with its linear address y*width+x, ready for the core image store.
//
// Ports
//   i_clk, i_reset         clock (rising edge) / async active-high reset
//   i_start                1-cycle pulse, latches i_width/i_height (IDLE only)
//   i_width, i_height      tile dimensions in pixels / rows
//   i_in_valid, o_in_ready, i_in_pixel      pixel input handshake
//   o_out_valid, i_out_ready, o_out_addr, o_out_sum   integral word output
//   o_busy                 high while a frame is running or draining
//   o_done                 1-cycle pulse at end of frame (also on bad dims)
//   o_err                  sticky illegal-dimension flag, cleared by next start
// ---------------------------------------------------------------------------
module integral_image_gen #(
    parameter int PIX_W  = 8,
    parameter int SUM_W  = 32,
    parameter int MAX_W  = 1024,
    parameter int ADDR_W = 17,
    parameter int DIM_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DIM_W-1:0]  i_width,
    input  logic [DIM_W-1:0]  i_height,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [PIX_W-1:0]  i_in_pixel,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [SUM_W-1:0]  o_out_sum,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    // Area limit is 2^ADDR_W entries; held one bit wider than the product.
    localparam logic [2*DIM_W:0] AREA_MAX = {{(2*DIM_W){1'b0}}, 1'b1} << ADDR_W;
    localparam logic [DIM_W-1:0] W_MAX    = DIM_W'(MAX_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Frame context
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_x;
    logic [DIM_W-1:0]  r_y;
    logic [SUM_W-1:0]  r_row_acc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    // Output register
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [SUM_W-1:0]  r_out_sum;

    // One row of previous integral values, indexed by column
    logic [SUM_W-1:0]  r_lbuf [MAX_W];

    logic              w_in_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_start_acc;
    logic              w_accept;
    logic              w_dims_bad;
    logic [2*DIM_W-1:0] w_area;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_last;
    logic [LB_AW-1:0]  w_x_idx;
    logic [SUM_W-1:0]  w_lb_rd;
    logic [SUM_W-1:0]  w_row_base;
    logic [SUM_W-1:0]  w_row_acc;
    logic [SUM_W-1:0]  w_above;
    logic [SUM_W-1:0]  w_sum;

    // ---------------------------------------------------------------- control
    assign w_area = {{DIM_W{1'b0}}, i_width} * {{DIM_W{1'b0}}, i_height};

    assign w_dims_bad = (i_width == '0) || (i_height == '0) ||
                        (i_width > W_MAX) || ({1'b0, w_area} > AREA_MAX);

    assign w_start_acc = i_start && (r_state == S_IDLE);
    assign w_accept    = i_in_valid && w_in_ready;

    assign w_x_last = (r_x == r_w - DIM_W'(1));
    assign w_y_last = (r_y == r_h - DIM_W'(1));
    assign w_last   = w_x_last && w_y_last;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = w_dims_bad ? S_DONE : S_RUN;
            S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
            // Wait until the final word has actually been taken downstream.
            S_DRAIN: if (r_out_valid && i_out_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            // Single output register: accept only if it is empty or draining now.
            S_RUN: begin
                w_busy     = 1'b1;
                w_in_ready = !r_out_valid || i_out_ready;
            end
            S_DRAIN: w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // --------------------------------------------------------------- datapath
    assign w_x_idx    = r_x[LB_AW-1:0];
    assign w_lb_rd    = r_lbuf[w_x_idx];
    assign w_row_base = (r_x == '0) ? '0 : r_row_acc;
    assign w_row_acc  = w_row_base + {{(SUM_W-PIX_W){1'b0}}, i_in_pixel};
    // Row 0 has nothing above it; the buffer may hold a previous frame there.
    assign w_above    = (r_y == '0) ? '0 : w_lb_rd;
    assign w_sum      = w_row_acc + w_above;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_w         <= '0;
            r_h         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_row_acc   <= '0;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_sum   <= '0;
        end else begin
            if (w_start_acc) begin
                r_w       <= i_width;
                r_h       <= i_height;
                r_x       <= '0;
                r_y       <= '0;
                r_row_acc <= '0;
                r_addr    <= '0;
                r_err     <= w_dims_bad;
            end

            if (w_accept) begin
                r_row_acc <= w_row_acc;
                r_addr    <= r_addr + ADDR_W'(1);
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + DIM_W'(1);
                end else begin
                    r_x <= r_x + DIM_W'(1);
                end
            end

            // A new accept refills the register even when the old word leaves.
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_addr;
                r_out_sum   <= w_sum;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Read-first line buffer: the read above sees the previous row's value.
    always_ff @(posedge i_clk) begin
        if (w_accept) r_lbuf[w_x_idx] <= w_sum;
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_addr  = r_out_addr;
    assign o_out_sum   = r_out_sum;
    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_integral_image_gen.sv
module tb_integral_image_gen;

    localparam int PIX_W  = 8;
    localparam int SUM_W  = 32;
    localparam int MAX_W  = 1024;
    localparam int ADDR_W = 17;
    localparam int DIM_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [DIM_W-1:0]  i_width = '0;
    logic [DIM_W-1:0]  i_height = '0;
    logic              i_in_valid = 1'b0;
    logic [PIX_W-1:0]  i_in_pixel = '0;
    logic              i_out_ready = 1'b1;
    logic              o_in_ready;
    logic              o_out_valid;
    logic [ADDR_W-1:0] o_out_addr;
    logic [SUM_W-1:0]  o_out_sum;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    integral_image_gen #(
        .PIX_W(PIX_W), .SUM_W(SUM_W), .MAX_W(MAX_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start),
        .i_width(i_width), .i_height(i_height),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_pixel(i_in_pixel),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_addr(o_out_addr), .o_out_sum(o_out_sum),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int rdy_mode = 0;          // 0: out_ready held high, 1: toggles every cycle
    int q_addr[$];
    int q_sum[$];
    int q_cyc[$];
    int done_cnt  = 0;
    int done_cyc  = 0;
    int valid_seen = 0;
    bit chk_stable = 1'b0;
    bit stall_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [SUM_W-1:0]  prev_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) i_out_ready = ~i_out_ready;
        else               i_out_ready = 1'b1;
    end

    // Beat collector and stall-stability monitor
    always @(negedge clk) begin
        if (o_out_valid) valid_seen++;
        if (chk_stable && stall_prev) begin
            chk("stall_valid", o_out_valid, 1);
            chk("stall_addr", o_out_addr, prev_addr);
            chk("stall_sum", o_out_sum, prev_sum);
        end
        if (o_out_valid && i_out_ready) begin
            q_addr.push_back(int'(o_out_addr));
            q_sum.push_back(int'(o_out_sum));
            q_cyc.push_back(cyc);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        stall_prev = o_out_valid && !i_out_ready;
        prev_addr  = o_out_addr;
        prev_sum   = o_out_sum;
    end

    task automatic do_start(input int w, input int h);
        i_width  = DIM_W'(w);
        i_height = DIM_W'(h);
        i_start  = 1'b1;
        @(posedge clk); #1;
        i_start  = 1'b0;
    endtask

    task automatic send_pix(input int p);
        int n;
        n = 0;
        i_in_valid = 1'b1;
        i_in_pixel = PIX_W'(p);
        do begin
            @(negedge clk);
            n++;
        end while (!o_in_ready && n < 200);
        if (!o_in_ready) chk("in_ready_wait", o_in_ready, 1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 200);
        chk(tag, o_done, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_beats(input string tag, input int e[$]);
        chk({tag, "_count"}, q_sum.size(), e.size());
        for (int i = 0; i < e.size() && i < q_sum.size(); i++) begin
            chk({tag, "_addr"}, q_addr[i], i);
            chk({tag, "_sum"}, q_sum[i], e[i]);
        end
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_sum.delete();
        q_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        int d0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_addr", o_out_addr, 0);
        chk("rst_out_sum", o_out_sum, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: 3x2 all ones
        clear_q();
        d0 = done_cnt;
        do_start(3, 2);
        chk("t1_busy", o_busy, 1);
        for (int i = 0; i < 6; i++) send_pix(1);
        wait_done("t1_done");
        e = {1, 2, 3, 2, 4, 6};
        check_beats("t1", e);
        chk("t1_done_cnt", done_cnt - d0, 1);
        if (q_cyc.size() == 6) chk("t1_done_lat", done_cyc - q_cyc[5], 1);
        chk("t1_err", o_err, 0);
        chk("t1_idle_busy", o_busy, 0);

        // T2: 2x2 with out_ready toggling
        clear_q();
        rdy_mode   = 1;
        chk_stable = 1'b1;
        do_start(2, 2);
        send_pix(10);
        send_pix(20);
        send_pix(30);
        send_pix(40);
        wait_done("t2_done");
        chk_stable = 1'b0;
        rdy_mode   = 0;
        @(posedge clk); #1;
        e = {10, 30, 40, 100};
        check_beats("t2", e);

        // T3: illegal dimensions
        valid_seen = 0;
        d0 = done_cnt;
        do_start(0, 2);
        chk("t3a_err", o_err, 1);
        chk("t3a_done", o_done, 1);
        chk("t3a_busy", o_busy, 0);
        @(posedge clk); #1;
        chk("t3a_done_fall", o_done, 0);
        chk("t3a_err_sticky", o_err, 1);
        do_start(MAX_W + 1, 1);
        chk("t3b_err", o_err, 1);
        chk("t3b_done", o_done, 1);
        @(posedge clk); #1;
        do_start(MAX_W, 129);
        chk("t3c_area_err", o_err, 1);
        @(posedge clk); #1;
        chk("t3_done_cnt", done_cnt - d0, 3);
        chk("t3_no_valid", valid_seen, 0);

        // T4: full-width 3-row frame, all 255
        clear_q();
        do_start(MAX_W, 3);
        chk("t4_err_clear", o_err, 0);
        for (int i = 0; i < 3 * MAX_W; i++) send_pix(255);
        wait_done("t4_done");
        chk("t4_count", q_sum.size(), 3 * MAX_W);
        if (q_sum.size() == 3 * MAX_W) begin
            chk("t4_row0_end", q_sum[MAX_W-1], 255 * MAX_W);
            chk("t4_row1_end", q_sum[2*MAX_W-1], 255 * MAX_W * 2);
            chk("t4_last_sum", q_sum[3*MAX_W-1], 255 * MAX_W * 3);
            chk("t4_last_addr", q_addr[3*MAX_W-1], 3 * MAX_W - 1);
        end

        // T5: reset in the middle of row 1
        d0 = done_cnt;
        do_start(4, 4);
        for (int i = 0; i < 6; i++) send_pix(i + 1);
        chk("t5_busy_pre", o_busy, 1);
        chk("t5_valid_pre", o_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", o_out_valid, 0);
        chk("t5_in_ready", o_in_ready, 0);
        chk("t5_out_addr", o_out_addr, 0);
        chk("t5_out_sum", o_out_sum, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_done", o_done, 0);
        chk("t5_err", o_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_no_done", done_cnt - d0, 0);
        clear_q();
        do_start(2, 2);
        for (int i = 0; i < 4; i++) send_pix(1);
        wait_done("t5_done2");
        e = {1, 2, 2, 4};
        check_beats("t5", e);

        // T6: start during RUN is ignored
        clear_q();
        do_start(2, 3);
        send_pix(1);
        send_pix(2);
        send_pix(3);
        do_start(5, 5);
        chk("t6_busy", o_busy, 1);
        chk("t6_err", o_err, 0);
        send_pix(4);
        send_pix(5);
        send_pix(6);
        wait_done("t6_done");
        e = {1, 3, 4, 10, 9, 21};
        check_beats("t6", e);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
